// File: rtl/elevator_pkg.sv
// Shared types and constants for the four-floor elevator controller.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 4;

    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DOWN    = 1'b0;
    localparam logic DOOR_OPEN   = 1'b1;
    localparam logic DOOR_CLOSED = 1'b0;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        MOVE = 2'd2
    } state_e;

endpackage

// File: rtl/elevator_controller_request_scan.sv
// Combinational SCAN helper: reports whether any pending request lies strictly ahead of
// or strictly behind the given floor, relative to the travel direction.
module request_scan
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  floor_t                floor_i,
    input  logic                  dir_i,
    output logic                  any_ahead_o,
    output logic                  any_behind_o
);

    logic any_above;
    logic any_below;

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_i[i]) begin
                if (i > int'(floor_i)) any_above = 1'b1;
                if (i < int'(floor_i)) any_below = 1'b1;
            end
        end
    end

    assign any_ahead_o  = (dir_i == DIR_UP) ? any_above : any_below;
    assign any_behind_o = (dir_i == DIR_UP) ? any_below : any_above;

endmodule

// File: rtl/elevator_controller.sv
// Four-floor SCAN elevator sequencer with timed travel and door dwell.
// Optional door hold input enabled by defining ELEVATOR_DOOR_HOLD_EN.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 50_000_000,
    parameter int unsigned DOOR_CYCLES   = 100_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req_btn,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [1:0]            current_floor,
    output logic                  ud_state,
    output logic                  oc_state,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    floor_t                  floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;

    floor_t                  arrive_floor;
    logic [NUM_FLOORS-1:0]   cur_mask;
    logic [NUM_FLOORS-1:0]   arrive_mask;
    logic [NUM_FLOORS-1:0]   merged;
    logic [NUM_FLOORS-1:0]   scan_pending;
    logic                    any_ahead;
    logic                    any_behind;

    assign arrive_floor = (dir_q == DIR_UP) ? floor_t'(floor_q + 2'd1)
                                            : floor_t'(floor_q - 2'd1);
    assign cur_mask     = NUM_FLOORS'(1) << floor_q;
    assign arrive_mask  = NUM_FLOORS'(1) << arrive_floor;
    assign merged       = pending_q | req_btn;

    // While moving, requests strictly ahead of floor_q other than the arrival floor are
    // exactly those strictly ahead of the arrival floor.
    assign scan_pending = (state_q == MOVE) ? (merged & ~arrive_mask) : pending_q;

    request_scan u_scan (
        .pending_i    (scan_pending),
        .floor_i      (floor_q),
        .dir_i        (dir_q),
        .any_ahead_o  (any_ahead),
        .any_behind_o (any_behind)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            floor_q   <= '0;
            dir_q     <= DIR_UP;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        // The current floor is serviced by the door rather than latched.
        pending_d = pending_q | (req_btn & ~cur_mask);

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (req_btn[floor_q]) begin
                    state_d = OPEN;
                end else if (any_ahead) begin
                    state_d = MOVE;
                end else if (any_behind) begin
                    dir_d   = ~dir_q;
                    state_d = MOVE;
                end
            end

            OPEN: begin
                if (req_btn[floor_q]) begin
                    timer_d = '0;
`ifdef ELEVATOR_DOOR_HOLD_EN
                end else if (door_hold) begin
                    timer_d = timer_q;
`endif
                end else if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            MOVE: begin
                pending_d = merged;
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    floor_d = arrive_floor;
                    // Arrival clear beats a same-cycle request for that floor.
                    if (merged[arrive_floor]) begin
                        pending_d = merged & ~arrive_mask;
                        state_d   = OPEN;
                    end else if (!any_ahead) begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign current_floor = floor_q;
    assign ud_state      = dir_q;
    assign oc_state      = (state_q == OPEN) ? DOOR_OPEN : DOOR_CLOSED;
    assign pending       = pending_q;

    a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == MOVE) |-> !((floor_q == 2'd3 && dir_q == DIR_UP) ||
                                (floor_q == 2'd0 && dir_q == DIR_DOWN)));

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller against a countdown-based behavioural model.
module tb_elevator_controller;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    localparam int MIDLE   = 0;
    localparam int MDOOR   = 1;
    localparam int MTRAVEL = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_btn;
    logic       door_hold;
    logic [1:0] current_floor;
    logic       ud_state;
    logic       oc_state;
    logic [3:0] pending;

    int vectors;
    int fails;

    // Behavioural model state
    int       m_floor;
    bit       m_dir;
    int       m_mode;
    int       m_left;
    bit [3:0] m_pend;

    elevator_controller #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR),
        .CNT_W         (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_btn       (req_btn),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold     (door_hold),
`endif
        .current_floor (current_floor),
        .ud_state      (ud_state),
        .oc_state      (oc_state),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit has_req(input bit [3:0] p, input int fl, input bit up);
        for (int f = 0; f < 4; f++) begin
            if (p[f] && (up ? (f > fl) : (f < fl))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_vec();
        return {2'(m_floor), m_dir, (m_mode == MDOOR), m_pend};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {current_floor, ud_state, oc_state, pending};
    endfunction

    task automatic model_reset();
        m_floor = 0;
        m_dir   = 1'b1;
        m_mode  = MIDLE;
        m_left  = 0;
        m_pend  = 4'b0000;
    endtask

    task automatic model_step(input logic [3:0] req, input bit hold);
        bit [3:0] old_pend;
        bit [3:0] here;
        old_pend = m_pend;
        here     = 4'b0000;
        here[m_floor] = 1'b1;
        case (m_mode)
            MIDLE: begin
                m_pend = m_pend | (req & ~here);
                if (req[m_floor]) begin
                    m_mode = MDOOR;
                    m_left = DOOR;
                end else if (has_req(old_pend, m_floor, m_dir)) begin
                    m_mode = MTRAVEL;
                    m_left = TRAVEL;
                end else if (has_req(old_pend, m_floor, !m_dir)) begin
                    m_dir  = !m_dir;
                    m_mode = MTRAVEL;
                    m_left = TRAVEL;
                end
            end
            MDOOR: begin
                m_pend = m_pend | (req & ~here);
                if (req[m_floor]) begin
                    m_left = DOOR;
                end else if (!hold) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = MIDLE;
                end
            end
            default: begin
                m_pend = m_pend | req;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                    if (m_pend[m_floor]) begin
                        m_pend[m_floor] = 1'b0;
                        m_mode = MDOOR;
                        m_left = DOOR;
                    end else if (!has_req(m_pend, m_floor, m_dir)) begin
                        m_mode = MIDLE;
                    end else begin
                        m_left = TRAVEL;
                    end
                end
            end
        endcase
    endtask

    // Drive one cycle of stimulus; returns at the following negedge.
    task automatic tick(input logic [3:0] req);
        req_btn = req;
        @(posedge clk);
        model_step(req, door_hold);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        req_btn   = 4'b0000;
        door_hold = 1'b0;
        do_reset();
        vectors++;
        if (dut_vec() !== 8'b00_1_0_0000) begin
            fails++;
            $display("FAIL reset got %b exp %b", dut_vec(), 8'b00_1_0_0000);
        end
    endtask

    task automatic test_door_reopen();
        int oc_cnt;
        oc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick((i == 0) ? 4'b0001 : 4'b0000);
            oc_cnt += int'(oc_state);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL door_open cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (oc_cnt !== 3) begin
            fails++;
            $display("FAIL door_dwell got %0d exp 3", oc_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            tick(4'b0001);
            vectors++;
            if (oc_state !== 1'b1 || pending !== 4'b0000) begin
                fails++;
                $display("FAIL door_reopen cyc%0d got oc=%b pend=%b exp oc=1 pend=0000",
                         i, oc_state, pending);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(4'b0000);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL door_release cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_pulse_top();
        int oc_cnt;
        oc_cnt = 0;
        tick(4'b1000);
        vectors++;
        if (pending !== 4'b1000) begin
            fails++;
            $display("FAIL pulse_latch got %b exp 1000", pending);
        end
        for (int i = 0; i < 20; i++) begin
            tick(4'b0000);
            oc_cnt += int'(oc_state);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL pulse_top cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (dut_vec() !== 8'b11_1_0_0000 || oc_cnt !== 3) begin
            fails++;
            $display("FAIL pulse_top_end got %b oc=%0d exp 11100000 oc=3", dut_vec(), oc_cnt);
        end
    endtask

    task automatic test_from_top();
        tick(4'b0010);
        for (int i = 0; i < 16; i++) begin
            tick(4'b0000);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL from_top cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (dut_vec() !== 8'b01_0_0_0000) begin
            fails++;
            $display("FAIL from_top_end got %b exp 01000000", dut_vec());
        end
    endtask

    task automatic test_scan_reverse();
        tick(4'b1000);
        tick(4'b0000);
        tick(4'b0001);
        vectors++;
        if (pending !== 4'b1001 || ud_state !== 1'b1) begin
            fails++;
            $display("FAIL scan_setup got pend=%b dir=%b exp pend=1001 dir=1", pending, ud_state);
        end
        for (int i = 0; i < 40; i++) begin
            tick(4'b0000);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL scan cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (dut_vec() !== 8'b00_0_0_0000) begin
            fails++;
            $display("FAIL scan_end got %b exp 00000000", dut_vec());
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        tick(4'b0100);
        tick(4'b0000);
        tick(4'b1000);
        tick(4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dut_vec() !== 8'b00_1_0_0000) begin
            fails++;
            $display("FAIL reset_mid_move got %b exp 00100000", dut_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(4'b0000);
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_mid_move_after got %b exp %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick(r);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc%0d req=%b got %b exp %b", i, r, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_idle_quiet();
        logic [7:0] snap;
        for (int i = 0; i < 200 && !(m_mode == MIDLE && m_pend == 4'b0000); i++) begin
            tick(4'b0000);
        end
        snap = exp_vec();
        for (int i = 0; i < 20; i++) begin
            tick(4'b0000);
            vectors++;
            if (dut_vec() !== snap || dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL idle_quiet cyc%0d got %b exp %b", i, dut_vec(), snap);
            end
        end
    endtask

`ifdef ELEVATOR_DOOR_HOLD_EN
    task automatic test_door_hold();
        int oc_cnt;
        logic [3:0] here;
        here = 4'b0000;
        here[m_floor] = 1'b1;
        oc_cnt = 0;
        tick(here);
        oc_cnt += int'(oc_state);
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(4'b0000);
            oc_cnt += int'(oc_state);
        end
        door_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(4'b0000);
            oc_cnt += int'(oc_state);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL door_hold cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (oc_cnt !== 13) begin
            fails++;
            $display("FAIL door_hold_len got %0d exp 13", oc_cnt);
        end
    endtask
`endif

    initial begin
        vectors   = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req_btn   = 4'b0000;
        door_hold = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_door_reopen();
        test_pulse_top();
        test_from_top();
        test_scan_reverse();
        test_reset_mid_move();
        test_random();
        test_idle_quiet();
`ifdef ELEVATOR_DOOR_HOLD_EN
        test_door_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
